// File: rtl/carry_lookahead_4bit.sv
// carry_lookahead_4bit: registered 4-bit carry-lookahead adder, answer/c_out = a + b + c_in.
// All carries are flattened sum-of-products of bit generate/propagate terms.
// Optional macro CLA_GROUP_PG_EN adds registered group generate/propagate outputs
// (g_grp, p_grp) for cascading into wider lookahead trees.
module carry_lookahead_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] answer,
    output logic       c_out
`ifdef CLA_GROUP_PG_EN
    ,
    output logic       g_grp,
    output logic       p_grp
`endif
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] sum_next;
    logic       grp_g;
    logic       grp_p;

    // Bit terms, parallel carries, sum and group terms (purely combinational)
    always_comb begin
        g = a & b;
        p = a ^ b;

        c    = '0;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_in);

        sum_next = p ^ c[3:0];

        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
    end

`ifdef CLA_GROUP_PG_EN
    // Output registers: sum, carry-out and group terms, reset to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            answer <= '0;
            c_out  <= 1'b0;
            g_grp  <= 1'b0;
            p_grp  <= 1'b0;
        end else begin
            answer <= sum_next;
            c_out  <= c[4];
            g_grp  <= grp_g;
            p_grp  <= grp_p;
        end
    end
`else
    logic unused_grp;
    assign unused_grp = grp_g ^ grp_p;

    // Output registers: sum and carry-out, reset to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            answer <= '0;
            c_out  <= 1'b0;
        end else begin
            answer <= sum_next;
            c_out  <= c[4];
        end
    end
`endif

endmodule

// File: tb/tb_carry_lookahead_4bit.sv
// tb_carry_lookahead_4bit: self-checking bench for carry_lookahead_4bit.
// Model: {c_out, answer} = a + b + c_in one cycle later, zero after a reset edge;
// group generate = (a + b > 15), group propagate = (a + b == 15).
module tb_carry_lookahead_4bit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       c_in = 1'b0;
    logic [3:0] answer;
    logic       c_out;
`ifdef CLA_GROUP_PG_EN
    logic       g_grp;
    logic       p_grp;
`endif

    int errors = 0;
    int checks = 0;

    carry_lookahead_4bit dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .c_in   (c_in),
        .answer (answer),
        .c_out  (c_out)
`ifdef CLA_GROUP_PG_EN
        ,
        .g_grp  (g_grp),
        .p_grp  (p_grp)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: capture expected results at each rising edge
    logic       valid = 1'b0;
    int         exp_sum5 = 0;
    int         exp_g = 0;
    int         exp_p = 0;

    always @(posedge clk) begin
        int s;
        s = int'(a) + int'(b);
        if (rst) begin
            valid    <= 1'b1;
            exp_sum5 <= 0;
            exp_g    <= 0;
            exp_p    <= 0;
        end else begin
            exp_sum5 <= s + int'(c_in);
            exp_g    <= (s > 15) ? 1 : 0;
            exp_p    <= (s == 15) ? 1 : 0;
        end
    end

    // Compare process: check DUT against the model on every falling edge
    always @(negedge clk) begin
        if (valid) begin
            chk("model_sum5", int'({c_out, answer}), exp_sum5);
`ifdef CLA_GROUP_PG_EN
            chk("model_g_grp", int'(g_grp), exp_g);
            chk("model_p_grp", int'(p_grp), exp_p);
            chk("model_invariant", int'(g_grp | (p_grp & c_out & ~g_grp) | (g_grp & c_out)),
                int'(c_out & (g_grp | p_grp)) | int'(g_grp));
`endif
        end
    end

    task automatic drive(input logic r, input logic [3:0] va, input logic [3:0] vb,
                         input logic vc);
        rst  = r;
        a    = va;
        b    = vb;
        c_in = vc;
    endtask

    // Invariant c4 = G | P*c_in checked against the c_in applied one edge earlier
    logic prev_cin = 1'b0;
    always @(posedge clk) prev_cin <= c_in;
`ifdef CLA_GROUP_PG_EN
    always @(negedge clk) begin
        if (valid && !rst)
            chk("g_or_p_cin", int'(g_grp | (p_grp & prev_cin)), int'(c_out));
    end
`endif

    initial begin
        @(negedge clk);
        drive(1'b1, 4'hF, 4'hF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("reset_answer", int'(answer), 0);
        chk("reset_c_out", int'(c_out), 0);
`ifdef CLA_GROUP_PG_EN
        chk("reset_g_grp", int'(g_grp), 0);
        chk("reset_p_grp", int'(p_grp), 0);
`endif
        drive(1'b0, 4'b1010, 4'b0110, 1'b0);
        @(negedge clk);
        chk("a6_answer", int'(answer), 0);
        chk("a6_c_out", int'(c_out), 1);
`ifdef CLA_GROUP_PG_EN
        chk("a6_g_grp", int'(g_grp), 1);
        chk("a6_p_grp", int'(p_grp), 0);
`endif
        drive(1'b0, 4'b1010, 4'b0110, 1'b1);
        @(negedge clk);
        chk("a6c_answer", int'(answer), 1);
        chk("a6c_c_out", int'(c_out), 1);
        drive(1'b0, 4'b0101, 4'b1010, 1'b1);
        @(negedge clk);
        chk("prop_c1_answer", int'(answer), 0);
        chk("prop_c1_c_out", int'(c_out), 1);
`ifdef CLA_GROUP_PG_EN
        chk("prop_g_grp", int'(g_grp), 0);
        chk("prop_p_grp", int'(p_grp), 1);
`endif
        drive(1'b0, 4'b0101, 4'b1010, 1'b0);
        @(negedge clk);
        chk("prop_c0_answer", int'(answer), 15);
        chk("prop_c0_c_out", int'(c_out), 0);

        // Exhaustive sweep, one operand set per cycle
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            drive(1'b0, v[3:0], v[7:4], v[8]);
            @(negedge clk);
        end

        // Mid-stream reset for one cycle with random operands
        drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
        @(negedge clk);
        chk("mid_reset_answer", int'(answer), 0);
        chk("mid_reset_c_out", int'(c_out), 0);
        drive(1'b0, 4'hF, 4'h1, 1'b1);
        @(negedge clk);
        chk("resume_answer", int'(answer), 1);
        chk("resume_c_out", int'(c_out), 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), 4'($urandom), 4'($urandom), 1'($urandom));
            @(negedge clk);
        end
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
